// File: rtl/ld_cnt_pkg.sv
// ld_cnt_pkg: shared constants and helpers for the loadable down-counter family.
package ld_cnt_pkg;
   localparam int LD_WIDTH_DEF = 4;
   localparam int WRAP = 0;
   localparam int RELOAD = 1;
   function automatic logic [31:0] all_ones(input int width);
      return (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
   endfunction
endpackage

// File: rtl/ld4p3_down_counter_if.sv
// ld4p3_down_counter_if: load/control/count bundle of one counter slice.
interface ld4p3_down_counter_if #(parameter int WIDTH = 4);
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic BI;
   logic SP;
   logic SD;
   logic PD;
   logic BO;
   logic TC;
   modport master (output D, BI, SP, SD, PD, input Q, BO, TC);
   modport slave (input D, BI, SP, SD, PD, output Q, BO, TC);
endinterface

// File: rtl/ld1_down_cell.sv
// ld1_down_cell: one counter bit; toggles when every lower bit is zero and borrow is in.
module ld1_down_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic sp,
   input  logic sd,
   input  logic pd,
   input  logic d,
   input  logic t,
   output logic q,
   output logic b
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else q <= sp ? (pd ? 1'b1 : sd ? d : q ^ t) : q;
   assign b = t & ~q;
endmodule

// File: rtl/ld4p3_down_counter.sv
// ld4p3_down_counter: cascadable loadable down-counter with optional auto-reload and
// a registered terminal-count pulse.
module ld4p3_down_counter
   import ld_cnt_pkg::*;
#(
   parameter int WIDTH = LD_WIDTH_DEF,
   parameter int AUTO_RELOAD = WRAP
) (
   input logic CK,
   input logic GSRN,
   ld4p3_down_counter_if.slave bus
);
   logic [WIDTH:0] t;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] rld;
   logic [WIDTH-1:0] ld_d;
   logic ld;
   logic tc;
   assign t[0] = bus.BI;
   // underflow in reload mode is just a load from rld; plain wrap falls out of the toggle chain
   assign ld = bus.SD | ((AUTO_RELOAD == RELOAD) & t[WIDTH]);
   assign ld_d = bus.SD ? bus.D : rld;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ld1_down_cell u_cell (
         .clk(CK),
         .rst_n(GSRN),
         .sp(bus.SP),
         .sd(ld),
         .pd(bus.PD),
         .d(ld_d[i]),
         .t(t[i]),
         .q(q[i]),
         .b(t[i+1])
      );
   end
   always_ff @(posedge CK or negedge GSRN)
      if (!GSRN) begin
         rld <= '0;
         tc <= 1'b0;
      end else begin
         rld <= (bus.SP & ~bus.PD & bus.SD) ? bus.D : rld;
         tc <= bus.SP & ~bus.PD & ~bus.SD & t[WIDTH];
      end
   assign bus.Q = q;
   assign bus.BO = t[WIDTH];
   assign bus.TC = tc;
endmodule
